// File: rtl/uart_pkg.sv
// Shared UART receiver types and default constants.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_CLK_DIV_DEF   = 43;
  localparam int UART_DATA_BITS_DEF = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } uart_rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a third flop for falling-edge detect.
// All flops reset to 1 so an idle-high line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_out = s2_q;
  assign fall     = s3_q & ~s2_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver: start-edge detect, mid-bit sampling, status flags.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV_DEF,
  parameter int DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err,
  output uart_rx_state_t       dbg_state_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (CLK_DIV < 8 || CLK_DIV > 1023) begin : g_bad_clk_div
    $error("uart_rx_param: CLK_DIV out of range 8..1023");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS out of range 5..9");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_rx_param: PARITY_ODD must be 0 or 1");
  end

  logic rx_s, rx_fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (RX),
    .sync_out (rx_s),
    .fall     (rx_fall)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 done;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // Only an edge starts a frame, so a line held low (break) stays idle.
        if (rx_fall) begin
          state_d = START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_q == HALF_LAST) begin
          baud_d  = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // Return to IDLE right at the stop sample; the last half bit is not waited out.
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    fe_d      = fe_q;
    ovr_d     = ovr_q;
`ifdef UART_RX_PARITY_EN
    pe_d      = pe_q;
`endif
    if (clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
    // Completion overrides a simultaneous acknowledge.
    if (done) begin
      rx_data_d = shift_q;
      rdy_d     = 1'b1;
      fe_d      = ~rx_s;
      if (rdy_q && !clr_rdy) ovr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      pe_d      = (^{shift_q, par_q}) != 1'(PARITY_ODD);
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rdy         = rdy_q;
  assign frame_err   = fe_q;
  assign overrun     = ovr_q;
  assign dbg_state_o = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = pe_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (CLK_DIV=43, 8 data bits).
// Parity cases are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CLK_DIV   = 43;
  localparam int DATA_BITS = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 RX;
  logic                 clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;
  uart_rx_state_t       dbg_state;

  int checks = 0;
  int errors = 0;

`ifdef UART_RX_PARITY_EN
  logic par_inv = 1'b0;
`endif

  uart_rx_param #(
    .CLK_DIV    (CLK_DIV),
    .DATA_BITS  (DATA_BITS),
    .PARITY_ODD (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .clr_rdy     (clr_rdy),
    .rx_data     (rx_data),
    .rdy         (rdy),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .parity_err  (parity_err),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // scoreboard helper
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // drivers (called on a negedge)
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    RX = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      RX = d[i];
      repeat (CLK_DIV) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RX = (^d) ^ par_inv;
    repeat (CLK_DIV) @(negedge clk);
`endif
    RX = stop_b;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[5];
  int   lat;

  initial begin
    vecs[0] = '{data: 8'h00, stop_b: 1'b1, exp_data: 8'h00, exp_fe: 1'b0};
    vecs[1] = '{data: 8'hFF, stop_b: 1'b1, exp_data: 8'hFF, exp_fe: 1'b0};
    vecs[2] = '{data: 8'h5A, stop_b: 1'b1, exp_data: 8'h5A, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h80, stop_b: 1'b0, exp_data: 8'h80, exp_fe: 1'b1};
    vecs[4] = '{data: 8'hC3, stop_b: 1'b1, exp_data: 8'hC3, exp_fe: 1'b0};

    rst_n   = 1'b0;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdy", rdy, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_state", dbg_state, IDLE);
    rst_n = 1'b1;
    idle(5);

    // clean frame with latency measured from the RX falling edge
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 1; k <= 600; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (rdy) begin
            lat = k;
            break;
          end
        end
      end
    join
    if (lat < 0) check("clean_rdy_timeout", 0, 1);
    else check("clean_latency_window", (lat >= 408 && lat <= 411), 1);
    check("clean_rx_data", rx_data, 8'hA5);
    check("clean_frame_err", frame_err, 0);
    check("clean_parity_err", parity_err, 0);
    idle(CLK_DIV);
    ack();
    check("clean_ack_rdy", rdy, 0);

    // table-driven frames
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_b);
      idle(CLK_DIV);
      check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_rdy", v), rdy, 1);
      check($sformatf("vec%0d_frame_err", v), frame_err, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), overrun, 0);
      ack();
      check($sformatf("vec%0d_ack_rdy", v), rdy, 0);
      check($sformatf("vec%0d_hold_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_hold_fe", v), frame_err, vecs[v].exp_fe);
    end

    // glitch rejection
    RX = 1'b0;
    repeat (10) @(negedge clk);
    idle(2 * CLK_DIV);
    check("glitch_state", dbg_state, IDLE);
    check("glitch_rdy", rdy, 0);
    send_frame(8'h3C, 1'b1);
    idle(CLK_DIV);
    check("post_glitch_rx_data", rx_data, 8'h3C);
    check("post_glitch_rdy", rdy, 1);
    ack();

    // framing error followed by a held-low line
    send_frame(8'h55, 1'b0);
    repeat (20 * CLK_DIV) @(negedge clk);
    check("break_frame_err", frame_err, 1);
    check("break_rdy", rdy, 1);
    check("break_rx_data", rx_data, 8'h55);
    check("break_no_retrigger_ovr", overrun, 0);
    check("break_state", dbg_state, IDLE);
    idle(2 * CLK_DIV);
    check("break_release_state", dbg_state, IDLE);
    ack();

    // overrun
    send_frame(8'h11, 1'b1);
    idle(CLK_DIV);
    send_frame(8'h22, 1'b1);
    idle(CLK_DIV);
    check("ovr_overrun", overrun, 1);
    check("ovr_rx_data", rx_data, 8'h22);
    check("ovr_rdy", rdy, 1);
    ack();
    check("ovr_ack_overrun", overrun, 0);
    check("ovr_ack_rdy", rdy, 0);

    // acknowledge coinciding with completion
    send_frame(8'h11, 1'b1);
    idle(CLK_DIV);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (410) @(posedge clk);
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    idle(CLK_DIV);
    check("prio_rdy", rdy, 1);
    check("prio_overrun", overrun, 0);
    check("prio_rx_data", rx_data, 8'h22);

`ifdef UART_RX_PARITY_EN
    ack();
    par_inv = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(CLK_DIV);
    check("par_good_rx_data", rx_data, 8'h07);
    check("par_good_parity_err", parity_err, 0);
    ack();
    par_inv = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(CLK_DIV);
    check("par_bad_parity_err", parity_err, 1);
    check("par_bad_rdy", rdy, 1);
    par_inv = 1'b0;
`endif

    // reset mid-frame after four data bits of 0xF0 (rdy still set from before)
    RX = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_rdy", rdy, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_parity_err", parity_err, 0);
    check("midrst_state", dbg_state, IDLE);
    RX = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(6 * CLK_DIV);
    check("midrst_idle_rdy", rdy, 0);
    check("midrst_idle_state", dbg_state, IDLE);
    send_frame(8'h81, 1'b1);
    idle(CLK_DIV);
    check("post_rst_rx_data", rx_data, 8'h81);
    check("post_rst_rdy", rdy, 1);
    check("post_rst_frame_err", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
